// File: rtl/mm_arb_pkg.sv
// Shared types and constants for the main-memory line arbiter.
package mm_arb_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 8;
  localparam int LINE_WORDS_DEF = 4;
  localparam int TIMEOUT_DEF    = 15;
  localparam int IDX_W          = $clog2(LINE_WORDS_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_rr_arbiter.sv
// Two-input round-robin: grant is combinational from the requests, while the
// priority pointer is a register that moves only when ptr_upd is asserted.
module mm_rr_arbiter (
  input  logic MM_clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic ptr_upd,
  input  logic ptr_nxt,
  output logic gnt_vld,
  output logic gnt_id
);

  logic ptr;

  assign gnt_vld = req0 | req1;
  assign gnt_id  = (req0 & req1) ? ptr : req1;

  always_ff @(posedge MM_clk) begin
    if (rst)          ptr <= 1'b0;
    else if (ptr_upd) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/mm_line_arbiter.sv
// Arbitrates two cache line requests onto the 256x8 main memory, sequencing
// each line as single-byte accesses and returning the line with a done/err pulse.
module mm_line_arbiter
  import mm_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                         MM_clk,
  input  logic                         rst,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         we0,
  input  logic                         we1,
  input  logic [ADDR_W-1:0]            addr0,
  input  logic [ADDR_W-1:0]            addr1,
  input  logic [DATA_W*LINE_WORDS-1:0] wline0,
  input  logic [DATA_W*LINE_WORDS-1:0] wline1,
  output logic [DATA_W*LINE_WORDS-1:0] rline,
  output logic                         done0,
  output logic                         done1,
  output logic                         err0,
  output logic                         err1,
  output logic                         busy,
  output logic [ADDR_W-1:0]            mm_read_select,
  output logic [ADDR_W-1:0]            mm_write_select,
  output logic [DATA_W-1:0]            mm_write_data,
  output logic                         mm_read_enable,
  output logic                         mm_write_enable,
  input  logic [DATA_W-1:0]            mm_out_data,
  input  logic                         mm_readfinish_flag,
  input  logic                         mm_writefinish_flag
);

  localparam int                IW    = cnt_bits(LINE_WORDS);
  localparam int                TW    = cnt_bits(TIMEOUT + 1);
  localparam int                LW    = DATA_W * LINE_WORDS;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(LINE_WORDS - 1);
  localparam logic [IW-1:0]     LAST  = IW'(LINE_WORDS - 1);
  localparam logic [TW-1:0]     TMAX  = TW'(TIMEOUT);

  state_t            state;
  logic              gid;
  logic              gwe;
  logic [ADDR_W-1:0] base;
  logic [LW-1:0]     wbuf;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tcnt;

  logic              gnt_vld;
  logic              gnt_id;
  logic              flag_hit;
  logic              go_issue;
  logic              iss_we;
  logic [IW-1:0]     iss_idx;
  logic [ADDR_W-1:0] iss_base;
  logic [LW-1:0]     iss_line;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_dat;

  mm_rr_arbiter u_rr (
    .MM_clk  (MM_clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .ptr_upd (state == S_DONE),
    .ptr_nxt (~gid),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign busy     = (state != S_IDLE);
  assign flag_hit = gwe ? mm_writefinish_flag : mm_readfinish_flag;
  assign go_issue = ((state == S_IDLE) && gnt_vld) ||
                    ((state == S_WAIT) && flag_hit && (idx != LAST));

  // Strobes are registered, so the next byte's access is computed one cycle
  // early: from the winning request in IDLE, from the latched line otherwise.
  always_comb begin
    iss_we   = gwe;
    iss_base = base;
    iss_line = wbuf;
    iss_idx  = idx + 1'b1;
    if (state == S_IDLE) begin
      iss_we   = gnt_id ? we1 : we0;
      iss_base = (gnt_id ? addr1 : addr0) & ALIGN;
      iss_line = gnt_id ? wline1 : wline0;
      iss_idx  = '0;
    end
    iss_addr = iss_base | ADDR_W'(iss_idx);
    iss_dat  = iss_line[iss_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge MM_clk) begin
    if (rst) begin
      state           <= S_IDLE;
      gid             <= 1'b0;
      gwe             <= 1'b0;
      base            <= '0;
      wbuf            <= '0;
      idx             <= '0;
      tcnt            <= '0;
      rline           <= '0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      err0            <= 1'b0;
      err1            <= 1'b0;
      mm_read_select  <= '0;
      mm_write_select <= '0;
      mm_write_data   <= '0;
      mm_read_enable  <= 1'b0;
      mm_write_enable <= 1'b0;
    end else begin
      mm_read_enable  <= 1'b0;
      mm_write_enable <= 1'b0;
      done0           <= 1'b0;
      done1           <= 1'b0;
      err0            <= 1'b0;
      err1            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            gid   <= gnt_id;
            gwe   <= iss_we;
            base  <= iss_base;
            wbuf  <= iss_line;
            idx   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (flag_hit) begin
            if (!gwe) rline[idx*DATA_W +: DATA_W] <= mm_out_data;
            if (idx == LAST) begin
              done0 <= ~gid;
              done1 <= gid;
              state <= S_DONE;
            end else begin
              idx   <= iss_idx;
              state <= S_ISSUE;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt + 1'b1 == TMAX) begin
              err0  <= ~gid;
              err1  <= gid;
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (go_issue) begin
        if (iss_we) begin
          mm_write_select <= iss_addr;
          mm_write_data   <= iss_dat;
          mm_write_enable <= 1'b1;
        end else begin
          mm_read_select  <= iss_addr;
          mm_read_enable  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mm_line_arbiter.md
Name: mm_line_arbiter

Overview:
- Two-requester arbiter and line sequencer in front of the 256x8 main memory.
- Requester 0 is the data cache; requester 1 is the instruction/second cache. Each request is a full line read (refill) or a full line write (write-back) of LINE_WORDS bytes.
- The block grants one requester at a time using round-robin. It breaks the line into single-byte memory accesses, waits for the memory finish flags, and returns the assembled line with a one-cycle done pulse.

Parameters:
- LINE_WORDS, 4, bytes per line; power of 2, range 1..16.
- TIMEOUT, 15, maximum cycles to wait for a finish flag per byte before aborting.

Ports:
- MM_clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1 each  request, level; held until the matching done or err
- we0, we1  in  1 each  1 = line write-back, 0 = line refill
- addr0, addr1  in  8 each  line base address; low log2(LINE_WORDS) bits ignored (treated as 0)
- wline0, wline1  in  8*LINE_WORDS each  write data; byte k in bits [8k+7:8k]
- rline  out  8*LINE_WORDS  refill data, shared by both requesters, valid while done is high
- done0, done1  out  1 each  one-cycle completion pulse
- err0, err1  out  1 each  one-cycle timeout-abort pulse
- busy  out  1  high in every state except IDLE
- mm_read_select, mm_write_select  out  8 each  memory addresses
- mm_write_data  out  8  memory write data
- mm_read_enable, mm_write_enable  out  1 each  memory strobes
- mm_out_data  in  8  memory read data
- mm_readfinish_flag, mm_writefinish_flag  in  1 each  memory completion pulses

Behaviour:
- Reset: state = IDLE; rline = 0; done*, err*, busy = 0; all mm_* outputs = 0; round-robin pointer = 0 (requester 0 preferred); byte index and timeout counter = 0.

State machine:
- IDLE:
  - If any req is high, grant per the pointer: a lone request wins; when both are high, the requester the pointer favours wins.
  - Latch grant id, we, aligned base address and wline. Clear the byte index. Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive address = base | index.
  - Write: mm_write_select = address, mm_write_data = byte[index], mm_write_enable = 1.
  - Read: mm_read_select = address, mm_read_enable = 1.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Strobes are 0; select and data lines hold their last values.
  - Only the flag matching the operation counts: mm_readfinish_flag for reads, mm_writefinish_flag for writes. The other flag is ignored.
  - On the matching flag: for a read, capture mm_out_data into rline byte[index] in the same cycle. Then:
    - if index == LINE_WORDS-1, go to DONE;
    - otherwise increment index and go to ISSUE.
  - If the counter reaches TIMEOUT with no flag: go to DONE with the abort flag set. rline bytes already captured are kept.
- DONE (1 cycle):
  - Pulse done[grant] on normal completion, or err[grant] on abort. Never pulse both.
  - Set pointer = the other requester. Go to IDLE.
- Latency per line: 1 (IDLE) + sum over bytes of (1 + memory flag latency) + 1 (DONE). A new grant is possible on the cycle after DONE.

Boundary and corner cases:
- Simultaneous requests: the loser waits. It is guaranteed service next, because the pointer flips after every transaction.
- Request drops mid-transaction: ignored. The transaction runs to completion and done still pulses.
- rst mid-transaction: abort immediately to the reset state. No done or err pulse. The memory may hold a partially written line.
- Address wrap: not possible inside a line, because the base is aligned and the index stays below LINE_WORDS.
- A flag arriving in IDLE, ISSUE or DONE is ignored.

Decomposition:
- Package mm_arb_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, DONE);
  - localparam IDX_W = $clog2(LINE_WORDS);
  - the ADDR_W = 8 and DATA_W = 8 constants.
- One sub-module, mm_rr_arbiter: 2-input round-robin with a pointer-update input. It is combinational grant logic plus the pointer register.

Test Plan:
- Reset then a single refill: req0 = 1, we0 = 0, addr0 = 0x10 on a freshly reset memory (all bytes 0x0F) -> mm_read_enable pulses 4 times at 0x10..0x13; done0 pulses once; rline = 0x0F0F0F0F; done1 and err* stay 0.
- Write-back then read-back: req1 write addr1 = 0x23 (treated as 0x20), wline1 = 0xDDCCBBAA -> bytes 0x20 = 0xAA, 0x21 = 0xBB, 0x22 = 0xCC, 0x23 = 0xDD; done1 pulses. A following req0 refill of 0x20 returns rline = 0xDDCCBBAA.
- Contention: req0 and req1 both asserted in the same cycle after reset -> requester 0 is served first, then requester 1 with no idle gap beyond IDLE. With both held for 4 transactions, grants alternate 0,1,0,1.
- Timeout: memory model suppresses mm_readfinish_flag at the third byte -> err0 pulses exactly TIMEOUT+1 cycles after that ISSUE; done0 never pulses; busy returns to 0.
- Reset mid-line: assert rst during WAIT of byte 2 of a write -> all outputs 0 on the next edge; no done or err pulse; the next request restarts from byte 0.
- Stray flags: inject mm_writefinish_flag during a read line and mm_readfinish_flag while in IDLE -> no state change and no extra captures.
